hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit_if.sv | 31 +++
 rtl/hazard_ctrl_unit.sv | 111 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Bus between the pipeline and the load-use hazard controller.
// The pipeline side (master) drives the decode/fetch information and the
// flush request. The controller side (slave) returns the stall controls and
// the episode counter.
interface hazard_ctrl_unit_if #(
  parameter int REG_W = 5,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
);
  logic             de_memrd;
  logic [TAG_W-1:0] de_wr_reg;
  logic [REG_W-1:0] f_rs1;
  logic [REG_W-1:0] f_rs2;
  logic             f_rs1_use;
  logic             f_rs2_use;
  logic             br_flush;
  logic             hdu_stall;
  logic             hdu_pcwr;
  logic             hdu_bubble;
  logic [CNT_W-1:0] stall_events;

  modport master (
    output de_memrd, de_wr_reg, f_rs1, f_rs2, f_rs1_use, f_rs2_use, br_flush,
    input  hdu_stall, hdu_pcwr, hdu_bubble, stall_events
  );

  modport slave (
    input  de_memrd, de_wr_reg, f_rs1, f_rs2, f_rs1_use, f_rs2_use, br_flush,
    output hdu_stall, hdu_pcwr, hdu_bubble, stall_events
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard controller.
// When the fetched instruction reads the destination of a load sitting in
// decode/execute, the front end is held for LOAD_LAT cycles and a bubble is
// injected. A branch flush cancels a pending or running stall. The number of
// stall episodes started is counted, and the counter saturates at all-ones.
// The interface instance must use the same REG_W/TAG_W/CNT_W as this module,
// and TAG_W must be at least REG_W.
module hazard_ctrl_unit #(
  parameter int REG_W     = 5,
  parameter int TAG_W     = 6,
  parameter int LOAD_LAT  = 1,
  parameter int ZERO_SKIP = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_ctrl_unit_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [3:0]       LAT     = 4'(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  state_t           state_next;
  logic [3:0]       cnt_reg;
  logic [3:0]       cnt_next;
  logic [CNT_W-1:0] events_reg;
  logic [CNT_W-1:0] events_next;

  logic [REG_W-1:0] wr_idx;
  logic             match1;
  logic             match2;
  logic             hazard;

  // Only the architectural register index part of the tag is compared.
  assign wr_idx = bus.de_wr_reg[REG_W-1:0];

  generate
    if (TAG_W > REG_W) begin : g_tag_hi
      // Upper tag bits carry no register identity and are deliberately dropped.
      logic unused_tag_hi;
      assign unused_tag_hi = ^bus.de_wr_reg[TAG_W-1:REG_W];
    end
  endgenerate

  // Hazard detection: a load whose destination is actually read by the
  // fetched instruction. Index 0 is hardwired zero when ZERO_SKIP is set.
  always_comb begin
    match1 = (wr_idx == bus.f_rs1) && !((ZERO_SKIP != 0) && (bus.f_rs1 == '0));
    match2 = (wr_idx == bus.f_rs2) && !((ZERO_SKIP != 0) && (bus.f_rs2 == '0));
    hazard = bus.de_memrd && ((bus.f_rs1_use && match1) || (bus.f_rs2_use && match2));
  end

  // State, down-counter and episode counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      events_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      events_reg <= events_next;
    end
  end

  // Next-state logic. Inside an episode the hazard input is ignored, so a
  // repeated hazard neither extends nor restarts the stall; a flush always
  // ends it at the next edge.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    events_next = events_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 4'd0;
        if (hazard && !bus.br_flush) begin
          state_next = STALL;
          cnt_next   = LAT;
          if (events_reg != CNT_MAX) begin
            events_next = events_reg + CNT_W'(1);
          end
        end
      end
      STALL: begin
        if (bus.br_flush || (cnt_reg <= 4'd1)) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs are a pure decode of registered state, with no path from inputs.
  assign bus.hdu_stall    = (state_reg == STALL);
  assign bus.hdu_pcwr     = (state_reg == STALL);
  assign bus.hdu_bubble   = (state_reg == STALL);
  assign bus.stall_events = events_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit. Two instances share one stimulus:
// dut_a (LOAD_LAT=3, ZERO_SKIP=1, CNT_W=16) and dut_b (LOAD_LAT=1,
// ZERO_SKIP=0, CNT_W=2). Table vectors, hand sequences and random stimulus
// are checked against a remaining-cycles reference model.
module tb_hazard_ctrl_unit;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int CW_A  = 16;
  localparam int CW_B  = 2;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       de_memrd = 1'b0;
  logic [5:0] wr = 6'd0;
  logic [4:0] rs1 = 5'd0;
  logic [4:0] rs2 = 5'd0;
  logic       u1 = 1'b0;
  logic       u2 = 1'b0;
  logic       br_flush = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_W(5), .TAG_W(6), .CNT_W(CW_A)) ifa ();
  hazard_ctrl_unit_if #(.REG_W(5), .TAG_W(6), .CNT_W(CW_B)) ifb ();

  assign ifa.de_memrd  = de_memrd;
  assign ifa.de_wr_reg = wr;
  assign ifa.f_rs1     = rs1;
  assign ifa.f_rs2     = rs2;
  assign ifa.f_rs1_use = u1;
  assign ifa.f_rs2_use = u2;
  assign ifa.br_flush  = br_flush;
  assign ifb.de_memrd  = de_memrd;
  assign ifb.de_wr_reg = wr;
  assign ifb.f_rs1     = rs1;
  assign ifb.f_rs2     = rs2;
  assign ifb.f_rs1_use = u1;
  assign ifb.f_rs2_use = u2;
  assign ifb.br_flush  = br_flush;

  hazard_ctrl_unit #(.REG_W(5), .TAG_W(6), .LOAD_LAT(LAT_A), .ZERO_SKIP(1), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  hazard_ctrl_unit #(.REG_W(5), .TAG_W(6), .LOAD_LAT(LAT_B), .ZERO_SKIP(0), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  // ---------------- reference model ----------------
  function automatic bit hz(input bit zskip);
    int  tag;
    bit  m1;
    bit  m2;
    tag = int'(wr) % 32;
    m1  = (tag == int'(rs1)) && !(zskip && rs1 == 0);
    m2  = (tag == int'(rs2)) && !(zskip && rs2 == 0);
    return de_memrd && ((u1 && m1) || (u2 && m2));
  endfunction

  int rem_a = 0, rem_b = 0, ev_a = 0, ev_b = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_a <= 0; rem_b <= 0; ev_a <= 0; ev_b <= 0;
    end else begin
      if (rem_a > 0) rem_a <= br_flush ? 0 : rem_a - 1;
      else if (hz(1'b1) && !br_flush) begin
        rem_a <= LAT_A;
        ev_a  <= (ev_a < MAX_A) ? ev_a + 1 : ev_a;
      end
      if (rem_b > 0) rem_b <= br_flush ? 0 : rem_b - 1;
      else if (hz(1'b0) && !br_flush) begin
        rem_b <= LAT_B;
        ev_b  <= (ev_b < MAX_B) ? ev_b + 1 : ev_b;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " a_stall"},  32'(ifa.hdu_stall),    32'(rem_a > 0));
    check({tag, " a_pcwr"},   32'(ifa.hdu_pcwr),     32'(rem_a > 0));
    check({tag, " a_bubble"}, 32'(ifa.hdu_bubble),   32'(rem_a > 0));
    check({tag, " a_events"}, 32'(ifa.stall_events), 32'(ev_a));
    check({tag, " b_stall"},  32'(ifb.hdu_stall),    32'(rem_b > 0));
    check({tag, " b_pcwr"},   32'(ifb.hdu_pcwr),     32'(rem_b > 0));
    check({tag, " b_bubble"}, 32'(ifb.hdu_bubble),   32'(rem_b > 0));
    check({tag, " b_events"}, 32'(ifb.stall_events), 32'(ev_b));
  endtask

  task automatic clear_inputs();
    de_memrd = 1'b0; wr = 6'd0; rs1 = 5'd0; rs2 = 5'd0;
    u1 = 1'b0; u2 = 1'b0; br_flush = 1'b0;
  endtask

  task automatic load_use_rs1();
    de_memrd = 1'b1; wr = 6'h05; rs1 = 5'd5; u1 = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       memrd;
    logic [5:0] wr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       fl;
    logic       ea;
    logic       eb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 6'h05, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // plain rs1 load-use
    vecs[1] = '{1'b1, 6'h00, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // x0 via rs2
    vecs[2] = '{1'b1, 6'h05, 5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // source unused
    vecs[3] = '{1'b0, 6'h05, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // not a load
    vecs[4] = '{1'b1, 6'h25, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // tag bit 5 ignored
    vecs[5] = '{1'b1, 6'h05, 5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // flush masks hazard
    vecs[6] = '{1'b1, 6'h0A, 5'd3,  5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // rs2 match
    vecs[7] = '{1'b1, 6'h0A, 5'd10, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // rs1 match unused
    vecs[8] = '{1'b1, 6'h00, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // x0 via rs1

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst a_stall",  32'(ifa.hdu_stall), 32'd0);
    check("rst a_pcwr",   32'(ifa.hdu_pcwr), 32'd0);
    check("rst a_bubble", 32'(ifa.hdu_bubble), 32'd0);
    check("rst a_events", 32'(ifa.stall_events), 32'd0);
    check("rst b_stall",  32'(ifb.hdu_stall), 32'd0);
    check("rst b_events", 32'(ifb.stall_events), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_model("post_rst");

    // table-driven single-edge vectors, each from an idle controller
    for (int i = 0; i < 9; i++) begin
      de_memrd = vecs[i].memrd; wr = vecs[i].wr; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      u1 = vecs[i].u1; u2 = vecs[i].u2; br_flush = vecs[i].fl;
      @(negedge clk);
      $display("vec %0d: memrd=%0d wr=%02h rs1=%0d rs2=%0d use=%0d%0d flush=%0d -> a=%0d b=%0d",
               i, de_memrd, wr, rs1, rs2, u1, u2, br_flush, ifa.hdu_stall, ifb.hdu_stall);
      check($sformatf("vec%0d a_stall", i), 32'(ifa.hdu_stall), 32'(vecs[i].ea));
      check($sformatf("vec%0d b_stall", i), 32'(ifb.hdu_stall), 32'(vecs[i].eb));
      check_model($sformatf("vec%0d", i));
      clear_inputs();
      @(negedge clk);
      check($sformatf("vec%0d b_one_cycle", i), 32'(ifb.hdu_stall), 32'd0);
      for (int k = 0; k < 3; k++) begin
        check_model($sformatf("vec%0d drain", i));
        @(negedge clk);
      end
    end

    // five separated hazards: 2-bit counter saturates at 3
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      load_use_rs1();
      @(negedge clk);
      clear_inputs();
      repeat (4) @(negedge clk);
      $display("sat hazard %0d: a_events=%0d b_events=%0d", i, ifa.stall_events, ifb.stall_events);
    end
    check("sat b_events", 32'(ifb.stall_events), 32'd3);
    check("sat a_events", 32'(ifa.stall_events), 32'd5);

    // LOAD_LAT=3 episode, hazard re-presented in stall cycle 2 does not extend
    load_use_rs1();
    @(negedge clk);
    check("lat3 c1", 32'(ifa.hdu_stall), 32'd1);
    @(negedge clk);
    check("lat3 c2", 32'(ifa.hdu_stall), 32'd1);
    check_model("lat3 c2");
    clear_inputs();
    @(negedge clk);
    check("lat3 c3", 32'(ifa.hdu_stall), 32'd1);
    @(negedge clk);
    check("lat3 end", 32'(ifa.hdu_stall), 32'd0);
    check("lat3 events", 32'(ifa.stall_events), 32'd6);
    $display("seq lat3: done, a_events=%0d", ifa.stall_events);

    // flush in second stall cycle ends the episode at the next edge
    load_use_rs1();
    @(negedge clk);
    clear_inputs();
    check("flush c1", 32'(ifa.hdu_stall), 32'd1);
    @(negedge clk);
    check("flush c2", 32'(ifa.hdu_stall), 32'd1);
    br_flush = 1'b1;
    @(negedge clk);
    check("flush cut", 32'(ifa.hdu_stall), 32'd0);
    check("flush cut pcwr", 32'(ifa.hdu_pcwr), 32'd0);
    br_flush = 1'b0;
    @(negedge clk);
    check("flush stays idle", 32'(ifa.hdu_stall), 32'd0);
    // flush together with a hazard in IDLE: nothing starts, count unchanged
    load_use_rs1();
    br_flush = 1'b1;
    @(negedge clk);
    check("flush+H a_stall", 32'(ifa.hdu_stall), 32'd0);
    check("flush+H b_stall", 32'(ifb.hdu_stall), 32'd0);
    check("flush+H events", 32'(ifa.stall_events), 32'd7);
    clear_inputs();
    @(negedge clk);
    $display("seq flush: done, a_events=%0d", ifa.stall_events);

    // held hazard: back-to-back episodes with a single IDLE cycle between
    load_use_rs1();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b c%0d", i), 32'(ifa.hdu_stall), 32'((i % 4) != 3));
      check_model($sformatf("b2b c%0d", i));
    end
    clear_inputs();
    check("b2b events", 32'(ifa.stall_events), 32'd9);
    repeat (4) @(negedge clk);
    $display("seq b2b: done, a_events=%0d", ifa.stall_events);

    // asynchronous reset in the middle of an episode
    load_use_rs1();
    @(negedge clk);
    clear_inputs();
    check("arst pre", 32'(ifa.hdu_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst a_stall",  32'(ifa.hdu_stall), 32'd0);
    check("arst a_pcwr",   32'(ifa.hdu_pcwr), 32'd0);
    check("arst a_bubble", 32'(ifa.hdu_bubble), 32'd0);
    check("arst a_events", 32'(ifa.stall_events), 32'd0);
    check("arst b_events", 32'(ifb.stall_events), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_model("arst release");
    $display("seq arst: done");

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      de_memrd = ($urandom_range(0, 9) < 7);
      wr       = 6'($urandom_range(0, 3) | ($urandom_range(0, 1) << 5));
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      u1       = 1'($urandom_range(0, 1));
      u2       = 1'($urandom_range(0, 1));
      br_flush = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      check_model($sformatf("rnd%0d", i));
      if (i % 50 == 0)
        $display("rnd %0d: a_stall=%0d a_events=%0d b_stall=%0d b_events=%0d",
                 i, ifa.hdu_stall, ifa.stall_events, ifb.hdu_stall, ifb.stall_events);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
